// File: rtl/seg_defs.sv
// Shared constants for the seven-segment scan path: digit count, special codes and the
// active-low segment patterns {g,f,e,d,c,b,a}.
package seg_defs;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [3:0] CODE_DASH = 4'hA;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Snapshot value meaning "nothing captured yet": every digit a dash.
  localparam logic [4*NUM_DIGITS-1:0] SHADOW_DASHES = {NUM_DIGITS{CODE_DASH}};

endpackage

// File: rtl/seven_seg_scan_decoder.sv
// Combinational BCD-to-segment decoder (active-low); codes above 9 other than the dash
// code blank the digit.
module seg_decoder
  import seg_defs::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (code_i)
      4'd0:      seg_o = SEG_0;
      4'd1:      seg_o = SEG_1;
      4'd2:      seg_o = SEG_2;
      4'd3:      seg_o = SEG_3;
      4'd4:      seg_o = SEG_4;
      4'd5:      seg_o = SEG_5;
      4'd6:      seg_o = SEG_6;
      4'd7:      seg_o = SEG_7;
      4'd8:      seg_o = SEG_8;
      4'd9:      seg_o = SEG_9;
      CODE_DASH: seg_o = SEG_DASH;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexes a 4-digit code word onto a common-anode display, snapshotting the input
// once per full scan. Optional colon blink on digit 2's dp: define SEG_COLON_BLINK_EN.
module seven_seg_scan
  import seg_defs::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100_000,
  parameter int unsigned CLK_HZ       = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nums,
  output logic [3:0]  digit,
  output logic [6:0]  display,
  output logic        dp
);

  localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      digit_q, digit_d;
  logic [6:0]      display_q;
  logic            dp_q, dp_d;
  logic            cnt_last;
  logic [3:0]      sel_code;
  logic [6:0]      sel_seg;

  assign cnt_last = (cnt_q == CntW'(DIGIT_CYCLES - 1));

  always_comb begin
    cnt_d    = cnt_q + CntW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (cnt_last) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      // Capture only on the 3->0 wrap so a frame never mixes two input words.
      if (idx_q == 2'd3) begin
        shadow_d = nums;
      end
    end
  end

  assign sel_code = shadow_q[{idx_q, 2'b00} +: 4];

  seg_decoder u_dec (
    .code_i (sel_code),
    .seg_o  (sel_seg)
  );

  assign digit_d = ~(4'b0001 << idx_q);

`ifdef SEG_COLON_BLINK_EN
  localparam int unsigned HalfHz = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int unsigned BlinkW = (HalfHz > 1) ? $clog2(HalfHz) : 1;

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BlinkW'(HalfHz - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    // Colon is suppressed while only dashes are on screen.
    dp_d = ~((idx_q == 2'd2) && blink_q && (shadow_q != SHADOW_DASHES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`else
  logic unused_clk_hz;
  assign unused_clk_hz = ^CLK_HZ;
  assign dp_d          = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= SHADOW_DASHES;
      digit_q   <= 4'b1111;
      display_q <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      digit_q   <= digit_d;
      display_q <= sel_seg;
      dp_q      <= dp_d;
    end
  end

  assign digit   = digit_q;
  assign display = display_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios then random nums/reset traffic,
// compared every cycle against a cycle-count based reference model.
module tb_seven_seg_scan;

  localparam int unsigned D    = 4;
  localparam int unsigned HZ   = 8;
  localparam int unsigned HALF = HZ / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] nums = 16'h0000;
  logic [3:0]  digit;
  logic [6:0]  display;
  logic        dp;

  int tests_run    = 0;
  int tests_failed = 0;

  seven_seg_scan #(
    .DIGIT_CYCLES (D),
    .CLK_HZ       (HZ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .nums    (nums),
    .digit   (digit),
    .display (display),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_table [16];
  initial begin
    seg_table[0]  = 7'b1000000; seg_table[1]  = 7'b1111001;
    seg_table[2]  = 7'b0100100; seg_table[3]  = 7'b0110000;
    seg_table[4]  = 7'b0011001; seg_table[5]  = 7'b0010010;
    seg_table[6]  = 7'b0000010; seg_table[7]  = 7'b1111000;
    seg_table[8]  = 7'b0000000; seg_table[9]  = 7'b0010000;
    seg_table[10] = 7'b0111111;
    for (int i = 11; i < 16; i++) seg_table[i] = 7'h7F;
  end

  // Model: n = non-reset edges since reset; after n edges the scan position is (n/D)%4 and
  // the snapshot holds nums as seen at the latest edge whose count is a multiple of 4*D.
  int unsigned m_n = 0;
  logic [15:0] m_shadow = 16'hAAAA;
  logic [3:0]  exp_digit = 4'b1111;
  logic [6:0]  exp_disp  = 7'h7F;
  logic        exp_dp    = 1'b1;
  logic        model_valid = 1'b0;

  function automatic logic [3:0] nib(input logic [15:0] w, input int unsigned k);
    logic [15:0] s;
    s = w >> (4 * k);
    return s[3:0];
  endfunction

  always @(posedge clk) begin
    int unsigned pos;
    model_valid <= 1'b1;
    if (rst) begin
      m_n       <= 0;
      m_shadow  <= 16'hAAAA;
      exp_digit <= 4'b1111;
      exp_disp  <= 7'h7F;
      exp_dp    <= 1'b1;
    end else begin
      pos       = (m_n / D) % 4;
      exp_digit <= ~(4'b0001 << pos);
      exp_disp  <= seg_table[nib(m_shadow, pos)];
`ifdef SEG_COLON_BLINK_EN
      exp_dp    <= !(pos == 2 && ((m_n / HALF) % 2) == 1 && m_shadow != 16'hAAAA);
`else
      exp_dp    <= 1'b1;
`endif
      m_n       <= m_n + 1;
      if (((m_n + 1) % (4 * D)) == 0) m_shadow <= nums;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs on the falling edge, then apply the next inputs.
  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (model_valid) begin
        check_eq("digit", {12'h0, digit}, {12'h0, exp_digit});
        check_eq("display", {9'h0, display}, {9'h0, exp_disp});
        check_eq("dp", {15'h0, dp}, {15'h0, exp_dp});
      end
    end
  endtask

  // Wait (bounded) until the model is at the given scan position.
  task automatic step_to_idx(input int unsigned want);
    for (int i = 0; i < 4 * D + 1; i++) begin
      if (!rst && ((m_n / D) % 4) == want) return;
      step(1);
    end
    check_eq("idx_wait", 16'h0, 16'h1);
  endtask

  initial begin
    rst  = 1'b1;
    nums = 16'h0000;
    step(3);
    // Directed constant checks during reset.
    check_eq("rst_digit", {12'h0, digit}, 16'h000F);
    check_eq("rst_display", {9'h0, display}, 16'h007F);
    rst  = 1'b0;
    nums = 16'h1234;
    // First frame of dashes, first digit after one cycle of latency.
    step(1);
    check_eq("dash_d0_digit", {12'h0, digit}, 16'h000E);
    check_eq("dash_d0_disp", {9'h0, display}, 16'h003F);
    step(4 * D + 2);
    check_eq("d0_is_4", {9'h0, display}, {9'h0, 7'b0011001});
    step(3 * D);

    step_to_idx(1);
    nums = 16'h5678;
    step(8 * D);

    nums = 16'hAAAA;
    step(12 * D);

    nums = 16'h0BF9;
    step(12 * D);

    step_to_idx(2);
    step(1);
    rst = 1'b1;
    step(1);
    check_eq("midrst_digit", {12'h0, digit}, 16'h000F);
    check_eq("midrst_disp", {9'h0, display}, 16'h007F);
    rst  = 1'b0;
    nums = 16'h0130;
    step(24 * D);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) nums = 16'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      step(1);
    end
    rst = 1'b0;
    step(8 * D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
